truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 109 ++++++++++
 tb/tb_truth_table_sweeper.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 input vectors through four implementations of a 4-input function and
// compares them with a reference truth table. Define STOP_ON_ERR_EN to end on the first mismatch.
module truth_table_sweeper #(
   parameter int SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] expected,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   input  logic [3:0]  s_in,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  err_count,
   output logic [3:0]  err_mask,
   output logic [3:0]  first_err_idx,
   output logic        first_err_vld
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state, state_nx;
   logic [3:0] idx;
   logic [3:0] settle_cnt;
   logic [3:0] m;
   logic       mis;

   assign m   = s_in ^ {4{expected[idx]}};
   assign mis = |m;

   // The stimulus is the vector index itself, so the inputs stay put after the sweep.
   assign {a, b, c, d} = idx;
   assign busy = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_SAMPLE);
   assign done = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start) state_nx = S_DRIVE;
         S_DRIVE:  state_nx = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
         S_SETTLE: if (settle_cnt == SETTLE_LAST) state_nx = S_SAMPLE;
         S_SAMPLE: begin
            if (idx == 4'd15) state_nx = S_DONE;
`ifdef STOP_ON_ERR_EN
            else if (mis)     state_nx = S_DONE;
`endif
            else              state_nx = S_DRIVE;
         end
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx           <= '0;
         settle_cnt    <= '0;
         pass          <= 1'b0;
         err_count     <= '0;
         err_mask      <= '0;
         first_err_idx <= '0;
         first_err_vld <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               idx           <= '0;
               pass          <= 1'b0;
               err_count     <= '0;
               err_mask      <= '0;
               first_err_vld <= 1'b0;
            end
            S_DRIVE:  settle_cnt <= '0;
            S_SETTLE: settle_cnt <= settle_cnt + 4'd1;
            S_SAMPLE: begin
               if (mis) begin
                  err_count <= err_count + 5'd1;
                  err_mask  <= err_mask | m;
                  if (!first_err_vld) begin
                     first_err_idx <= idx;
                     first_err_vld <= 1'b1;
                  end
               end
               if (state_nx == S_DRIVE) idx <= idx + 4'd1;
               // Verdict is settled on entry to DONE so it is visible alongside the done pulse.
               if (state_nx == S_DONE)  pass <= (err_count == 5'd0) && !mis;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a sweep-level model derived from elapsed cycles since
// the accepted start is compared every cycle, plus literal checks for each scenario.
module tb_truth_table_sweeper;
   localparam int S = 1;
   localparam int P = S + 2;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] expected;
   logic        a, b, c, d;
   logic [3:0]  s_in;
   logic        busy, done, pass;
   logic [4:0]  err_count;
   logic [3:0]  err_mask, first_err_idx;
   logic        first_err_vld;
   logic [3:0]  vec;
   logic [3:0]  flt  [16];
   logic [3:0]  mflt [16];

   int errors = 0, checks = 0;
   int t = -1, cyc = 0;
   bit swept = 0, chk_en = 0;

   truth_table_sweeper #(.SETTLE(S)) dut (
      .clk(clk), .rst(rst), .start(start), .expected(expected),
      .a(a), .b(b), .c(c), .d(d), .s_in(s_in),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .err_mask(err_mask), .first_err_idx(first_err_idx), .first_err_vld(first_err_vld)
   );

   always #5 clk = ~clk;

   // Implementations under test: all correct, with per-vector fault bits flipped in.
   assign vec = {a, b, c, d};
   always_comb s_in = {4{expected[vec]}} ^ flt[vec];

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int last_vec();
      int l = 15;
`ifdef STOP_ON_ERR_EN
      for (int v = 15; v >= 0; v--) if (mflt[v] != 4'd0) l = v;
`endif
      return l;
   endfunction

   // Model timeline: t counts cycles since the accepted start edge, -1 while idle.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         t = -1; swept = 0;
      end else if (t < 0) begin
         if (start) begin
            t = 0;
            for (int v = 0; v < 16; v++) mflt[v] = flt[v];
         end
      end else begin
         t++;
         if (t > (last_vec() + 1) * P) begin t = -1; swept = 1; end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         int l, n, ec, fi, ev;
         bit bsy, dn, fv, ps;
         logic [3:0] mk;
         l   = last_vec();
         bsy = (t >= 0) && (t < (l + 1) * P);
         dn  = (t == (l + 1) * P);
         if (t < 0) begin
            n  = swept ? l + 1 : 0;
            ev = swept ? l : 0;
         end else begin
            n  = (t / P < l + 1) ? t / P : l + 1;
            ev = (t / P < l + 1) ? t / P : l;
         end
         ec = 0; mk = 4'd0; fv = 0; fi = 0;
         for (int v = 0; v < n; v++)
            if (mflt[v] != 4'd0) begin
               ec++; mk |= mflt[v];
               if (!fv) begin fv = 1; fi = v; end
            end
         ps = ((t < 0 && swept) || dn) && (ec == 0);
         chk("busy", busy, bsy);
         chk("done", done, dn);
         chk("vec", vec, ev);
         chk("err_count", err_count, ec);
         chk("err_mask", err_mask, mk);
         chk("first_err_vld", first_err_vld, fv);
         chk("pass", pass, ps);
         if (fv || (t < 0 && !swept)) chk("first_err_idx", first_err_idx, fi);
      end
   end

   task automatic wait_done(output int cy);
      bit found = 0;
      cy = -1;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin found = 1; cy = cyc; end
      end
      if (!found) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done expected done within 300 cycles");
      end
   endtask

   task automatic run_sweep(output int lat);
      int k, cy;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 k = cyc; start = 1'b0;
      wait_done(cy);
      lat = cy - k;
   endtask

   initial begin
      int lat, c1, c2;
      bit hit;
      rst = 1'b1; start = 1'b0; expected = 16'h5363;
      for (int v = 0; v < 16; v++) flt[v] = 4'd0;
      @(posedge clk); @(posedge clk); #1 chk_en = 1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_vec", vec, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Clean sweep
      run_sweep(lat);
      chk("clean_latency", lat, 48);
      chk("clean_pass", pass, 1);
      chk("clean_err_count", err_count, 0);
      chk("clean_err_mask", err_mask, 0);
      chk("clean_first_vld", first_err_vld, 0);
      repeat (3) @(posedge clk);

      // Single fault on the simplified SoP at vector 13
      flt[13] = 4'b0010;
      run_sweep(lat);
      chk("v13_err_count", err_count, 1);
      chk("v13_first_idx", first_err_idx, 13);
      chk("v13_first_vld", first_err_vld, 1);
      chk("v13_err_mask", err_mask, 4'b0010);
      chk("v13_pass", pass, 0);

      // Every implementation wrong at every vector
      for (int v = 0; v < 16; v++) flt[v] = 4'hF;
      run_sweep(lat);
`ifdef STOP_ON_ERR_EN
      chk("all_err_count", err_count, 1);
`else
      chk("all_err_count", err_count, 16);
`endif
      chk("all_err_mask", err_mask, 4'hF);
      chk("all_first_idx", first_err_idx, 0);

`ifdef STOP_ON_ERR_EN
      for (int v = 0; v < 16; v++) flt[v] = 4'd0;
      flt[3] = 4'b0001; flt[9] = 4'b0001;
      run_sweep(lat);
      chk("stop_latency", lat, 12);
      chk("stop_err_count", err_count, 1);
      chk("stop_first_idx", first_err_idx, 3);
      chk("stop_vec", vec, 4'b0011);
`endif

      // Reset in the middle of a sweep
      for (int v = 0; v < 16; v++) flt[v] = 4'd0;
      flt[2] = 4'b0100;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         if (vec == 4'd7) hit = 1;
      end
      chk("reach_vec7", hit, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_err_count", err_count, 0);
      chk("midrst_first_vld", first_err_vld, 0);
      chk("midrst_vec", vec, 0);
      for (int v = 0; v < 16; v++) flt[v] = 4'd0;
      run_sweep(lat);
      chk("post_rst_pass", pass, 1);

      // Start pulsed mid-sweep must not disturb timing
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 c1 = cyc; start = 1'b0;
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(c2);
      chk("busy_start_latency", c2 - c1, 48);

      // Held start: back-to-back sweeps with one idle cycle between
      @(posedge clk); #1 start = 1'b1;
      wait_done(c1);
      @(negedge clk);
      wait_done(c2);
      chk("b2b_spacing", c2 - c1, 50);
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
